// File: rtl/apb_i2c_seq.sv
// rtl/apb_i2c_seq.sv - APB master sequencer driving the APB-to-I2C bridge from a command interface
//
// Each accepted command writes CONFIG (0x8) and TIMEOUT (0xC). It then streams cmd_len
// words into the TX FIFO (0x0), or pops them from the RX FIFO (0x4), and finishes with a
// one-cycle done strobe that carries err.
//
// Ports
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_rd, cmd_len, cmd_config, cmd_timeout)
//   wdata_valid/wdata_ready/wdata write words supplied by the host
//   rdata_valid/rdata             one-cycle strobe with each word read from the RX FIFO
//   done/err                      completion strobe; err 00 ok, 01 PSLVERR, 10 watchdog
//   PSEL..PSLVERR                 APB master port
//   INT_TX/INT_RX                 TX FIFO empty / RX FIFO empty flags from the bridge
module apb_i2c_seq #(
   parameter int LEN_W    = 8,
   parameter int WAIT_MAX = 255
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rd,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [13:0]      cmd_config,
   input  logic [13:0]      cmd_timeout,
   input  logic             wdata_valid,
   output logic             wdata_ready,
   input  logic [31:0]      wdata,
   output logic             rdata_valid,
   output logic [31:0]      rdata,
   output logic             done,
   output logic [1:0]       err,
   output logic             PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [31:0]      PADDR,
   output logic [31:0]      PWDATA,
   input  logic [31:0]      PRDATA,
   input  logic             PREADY,
   input  logic             PSLVERR,
   input  logic             INT_TX,
   input  logic             INT_RX
);

   localparam int WD_W = $clog2(WAIT_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, CFG_S, CFG_A, TMO_S, TMO_A, W_WAIT, W_S, W_A,
      R_WAIT, R_S, R_A, DRAIN, FIN
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             rd_q, rd_d;
   logic [13:0]      tmo_q, tmo_d;
   logic [31:0]      paddr_q, paddr_d;
   logic [31:0]      pwdata_q, pwdata_d;
   logic             pwrite_q, pwrite_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rdata_valid_q, rdata_valid_d;
   logic [1:0]       err_q, err_d;

   logic             is_acc, is_setup, wd_hit, watched;
   logic [LEN_W-1:0] cnt_dec;

   assign is_acc   = (state_q == CFG_A) || (state_q == TMO_A) || (state_q == W_A) || (state_q == R_A);
   assign is_setup = (state_q == CFG_S) || (state_q == TMO_S) || (state_q == W_S) || (state_q == R_S);
   // Trips on the WAIT_MAX-th watched cycle, so the wait lasts exactly WAIT_MAX cycles.
   assign wd_hit   = (wd_q == WD_W'(WAIT_MAX - 1));
   assign cnt_dec  = cnt_q - LEN_W'(1);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rd_d          = rd_q;
      tmo_d         = tmo_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pwrite_d      = pwrite_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      err_d         = err_q;
      watched       = 1'b0;

      // Common access-phase exits. A slave error can only be seen with PREADY=1, which
      // never counts as a watched cycle, so PSLVERR always wins over the watchdog.
      if (is_acc) begin
         if (PREADY && PSLVERR) begin
            err_d   = 2'b01;
            state_d = FIN;
         end else if (!PREADY) begin
            watched = 1'b1;
            if (wd_hit) begin
               err_d   = 2'b10;
               state_d = FIN;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               rd_d     = cmd_rd;
               tmo_d    = cmd_timeout;
               cnt_d    = cmd_len;
               err_d    = 2'b00;
               paddr_d  = 32'd8;
               pwrite_d = 1'b1;
               pwdata_d = {18'b0, cmd_config};
               state_d  = CFG_S;
            end
         end
         CFG_S: state_d = CFG_A;
         TMO_S: state_d = TMO_A;
         W_S:   state_d = W_A;
         R_S:   state_d = R_A;
         CFG_A: begin
            if (PREADY && !PSLVERR) begin
               paddr_d  = 32'd12;
               pwrite_d = 1'b1;
               pwdata_d = {18'b0, tmo_q};
               state_d  = TMO_S;
            end
         end
         TMO_A: begin
            if (PREADY && !PSLVERR) begin
               if (cnt_q == '0)  state_d = FIN;
               else if (rd_q)    state_d = R_WAIT;
               else              state_d = W_WAIT;
            end
         end
         W_WAIT: begin
            if (wdata_valid) begin
               pwdata_d = wdata;
               paddr_d  = 32'd0;
               pwrite_d = 1'b1;
               state_d  = W_S;
            end
         end
         W_A: begin
            if (PREADY && !PSLVERR) begin
               cnt_d   = cnt_dec;
               state_d = (cnt_dec != '0) ? W_WAIT : DRAIN;
            end
         end
         R_WAIT: begin
            if (!INT_RX) begin
               paddr_d  = 32'd4;
               pwrite_d = 1'b0;
               state_d  = R_S;
            end else begin
               watched = 1'b1;
               if (wd_hit) begin
                  err_d   = 2'b10;
                  state_d = FIN;
               end
            end
         end
         R_A: begin
            if (PREADY && !PSLVERR) begin
               rdata_d       = PRDATA;
               rdata_valid_d = 1'b1;
               cnt_d         = cnt_dec;
               state_d       = (cnt_dec != '0) ? R_WAIT : FIN;
            end
         end
         DRAIN: begin
            if (INT_TX) begin
               state_d = FIN;
            end else begin
               watched = 1'b1;
               if (wd_hit) begin
                  err_d   = 2'b10;
                  state_d = FIN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The watchdog restarts on every state change, including W_A -> W_WAIT -> W_S.
      if (state_d != state_q)  wd_d = '0;
      else if (watched)        wd_d = wd_q + WD_W'(1);
      else                     wd_d = wd_q;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         wd_q          <= '0;
         rd_q          <= 1'b0;
         tmo_q         <= '0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         err_q         <= 2'b00;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wd_q          <= wd_d;
         rd_q          <= rd_d;
         tmo_q         <= tmo_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         err_q         <= err_d;
      end
   end

   // Select/enable come straight from the state, so reset drops them without a clock.
   assign PSEL        = is_acc || is_setup;
   assign PENABLE     = is_acc;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign cmd_ready   = (state_q == IDLE);
   assign wdata_ready = (state_q == W_WAIT);
   assign done        = (state_q == FIN);
   assign err         = err_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_apb_i2c_seq.sv
// tb/tb_apb_i2c_seq.sv - directed self-checking bench for apb_i2c_seq
module tb_apb_i2c_seq;
   localparam int LEN_W    = 8;
   localparam int WAIT_MAX = 16;

   logic             PCLK, PRESETn;
   logic             cmd_valid, cmd_ready, cmd_rd;
   logic [LEN_W-1:0] cmd_len;
   logic [13:0]      cmd_config, cmd_timeout;
   logic             wdata_valid, wdata_ready;
   logic [31:0]      wdata;
   logic             rdata_valid;
   logic [31:0]      rdata;
   logic             done;
   logic [1:0]       err;
   logic             PSEL, PENABLE, PWRITE;
   logic [31:0]      PADDR, PWDATA, PRDATA;
   logic             PREADY, PSLVERR, INT_TX, INT_RX;

   apb_i2c_seq #(.LEN_W(LEN_W), .WAIT_MAX(WAIT_MAX)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_len(cmd_len),
      .cmd_config(cmd_config), .cmd_timeout(cmd_timeout),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .INT_TX(INT_TX), .INT_RX(INT_RX)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;

   // Monitor state (sampled on the falling edge)
   int          cyc = 0;
   logic [31:0] mon_addr[$];
   logic [31:0] mon_data[$];
   logic        mon_wr[$];
   int          mon_len[$];
   int          mon_n = 0, mon_tx = 0, mon_rdc = 0;
   int          acc_run = 0, unstable = 0, acc8 = 0, bad_rd = 0;
   logic [31:0] acc_addr, acc_data;
   logic        acc_wr;
   logic        int_rx_prev = 1'b1;
   logic [31:0] rdv[$];
   int          done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
   logic [1:0]  done_err = 2'b00;
   logic        psel_at_done = 1'b0;

   // Slave / host model controls
   logic        stuck = 1'b0;
   logic        err_en = 1'b0;
   logic [31:0] wait_addr = 32'hFFFF_FFFF;
   int          wait_n = 0;
   int          acc = 0, rx_timer = 0, last_n = 0;
   logic        in_acc = 1'b0;
   logic [31:0] wq[$];
   logic [31:0] rd_vals [0:3];

   always @(negedge PCLK) begin
      cyc++;
      if (PSEL && PENABLE) begin
         if (acc_run == 0) begin
            acc_addr = PADDR; acc_data = PWDATA; acc_wr = PWRITE;
         end else if (PADDR !== acc_addr || PWDATA !== acc_data || PWRITE !== acc_wr) begin
            unstable++;
         end
         acc_run++;
         if (PADDR == 32'd8) acc8++;
         if (PREADY) begin
            mon_addr.push_back(PADDR);
            mon_data.push_back(PWRITE ? PWDATA : PRDATA);
            mon_wr.push_back(PWRITE);
            mon_len.push_back(acc_run);
            mon_n++;
            if (PWRITE && PADDR == 32'd0) mon_tx++;
            if (!PWRITE) mon_rdc++;
            last_xfer_cyc = cyc;
            acc_run = 0;
         end
      end else begin
         acc_run = 0;
      end
      if (PSEL && !PENABLE && !PWRITE && int_rx_prev) bad_rd++;
      int_rx_prev = INT_RX;
      if (rdata_valid) rdv.push_back(rdata);
      if (done) begin
         done_cnt++; done_err = err; done_cyc = cyc; psel_at_done = PSEL;
      end
      if (wdata_valid && wdata_ready) void'(wq.pop_front());
   end

   always @(posedge PCLK) begin
      #1;
      if (PSEL && PENABLE) begin
         acc    = in_acc ? acc + 1 : 0;
         in_acc = 1'b1;
      end else begin
         in_acc = 1'b0;
      end
      PREADY  = stuck ? 1'b0 : ((PADDR == wait_addr && acc < wait_n) ? 1'b0 : 1'b1);
      PSLVERR = err_en && PSEL && PWRITE && PADDR == 32'd0 && mon_tx == 1;
      PRDATA  = rd_vals[mon_rdc[1:0]];
      if (mon_n != last_n) begin
         rx_timer = 0; last_n = mon_n;
      end
      INT_RX = (rx_timer < 5);
      rx_timer++;
      wdata_valid = (wq.size() > 0);
      wdata       = (wq.size() > 0) ? wq[0] : 32'd0;
   end

   task automatic step(int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      mon_addr.delete(); mon_data.delete(); mon_wr.delete(); mon_len.delete(); rdv.delete();
      mon_n = 0; mon_tx = 0; mon_rdc = 0; last_n = 0;
      unstable = 0; acc8 = 0; bad_rd = 0; done_cnt = 0;
   endtask

   task automatic issue(logic rd, int len, logic [13:0] cfg, logic [13:0] tmo);
      int n = 0;
      while (!cmd_ready && n < 200) begin step(1); n++; end
      chk("cmd_ready_before_issue", {31'b0, cmd_ready}, 32'd1);
      cmd_rd = rd; cmd_len = len[LEN_W-1:0]; cmd_config = cfg; cmd_timeout = tmo;
      cmd_valid = 1'b1;
      step(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(string tag);
      int n = 0;
      while (done_cnt < 1 && n < 500) begin step(1); n++; end
      chk(tag, done_cnt, 32'd1);
      step(2);
   endtask

   int saved_done;

   initial begin
      rd_vals[0] = 32'h11; rd_vals[1] = 32'h22; rd_vals[2] = 32'h33; rd_vals[3] = 32'h44;
      cmd_valid = 0; cmd_rd = 0; cmd_len = '0; cmd_config = '0; cmd_timeout = '0;
      wdata_valid = 0; wdata = '0; PRDATA = '0; PREADY = 1; PSLVERR = 0; INT_TX = 1; INT_RX = 1;
      PRESETn = 1'b1;
      #1 PRESETn = 1'b0;
      #1;
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_psel_penable_pwrite", {29'b0, PSEL, PENABLE, PWRITE}, 32'd0);
      chk("rst_paddr", PADDR, 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_strobes", {28'b0, rdata_valid, done, wdata_ready, 1'b0}, 32'd0);
      chk("rst_err", {30'b0, err}, 32'd0);
      step(2);
      PRESETn = 1'b1;
      step(2);

      // Write, len=2, PREADY always 1
      clear_mon();
      wq.push_back(32'hA5A5_0001); wq.push_back(32'hA5A5_0002);
      issue(1'b0, 2, 14'h0123, 14'h00FF);
      wait_done("wr_done");
      chk("wr_err", {30'b0, done_err}, 32'd0);
      chk("wr_nxfer", mon_n, 32'd4);
      chk("wr_a0", mon_addr[0], 32'd8);   chk("wr_d0", mon_data[0], 32'h123);
      chk("wr_a1", mon_addr[1], 32'd12);  chk("wr_d1", mon_data[1], 32'hFF);
      chk("wr_a2", mon_addr[2], 32'd0);   chk("wr_d2", mon_data[2], 32'hA5A5_0001);
      chk("wr_a3", mon_addr[3], 32'd0);   chk("wr_d3", mon_data[3], 32'hA5A5_0002);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wr_len%0d", i), mon_len[i], 32'd1);
         chk($sformatf("wr_dir%0d", i), {31'b0, mon_wr[i]}, 32'd1);
      end
      chk("wr_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);

      // Read, len=3, RX empty 5 cycles before each word
      clear_mon();
      issue(1'b1, 3, 14'h0001, 14'h0002);
      wait_done("rd_done");
      chk("rd_err", {30'b0, done_err}, 32'd0);
      chk("rd_nxfer", mon_n, 32'd5);
      for (int i = 2; i < 5; i++) begin
         chk($sformatf("rd_addr%0d", i), mon_addr[i], 32'd4);
         chk($sformatf("rd_dir%0d", i), {31'b0, mon_wr[i]}, 32'd0);
      end
      chk("rd_nstrobe", rdv.size(), 32'd3);
      chk("rd_v0", rdv[0], 32'h11);
      chk("rd_v1", rdv[1], 32'h22);
      chk("rd_v2", rdv[2], 32'h33);
      chk("rd_only_when_not_empty", bad_rd, 32'd0);

      // PREADY low for 4 cycles on the TIMEOUT access
      clear_mon();
      wait_addr = 32'd12; wait_n = 4;
      wq.push_back(32'h0000_BEEF);
      issue(1'b0, 1, 14'h0005, 14'h0006);
      wait_done("ws_done");
      wait_addr = 32'hFFFF_FFFF;
      chk("ws_nxfer", mon_n, 32'd3);
      chk("ws_tmo_addr", mon_addr[1], 32'd12);
      chk("ws_tmo_len", mon_len[1], 32'd5);
      chk("ws_cfg_len", mon_len[0], 32'd1);
      chk("ws_stable", unstable, 32'd0);
      chk("ws_word", mon_data[2], 32'h0000_BEEF);
      chk("ws_err", {30'b0, done_err}, 32'd0);

      // PSLVERR on the 2nd of 4 TX writes
      clear_mon();
      err_en = 1'b1;
      wq.push_back(32'h1); wq.push_back(32'h2); wq.push_back(32'h3); wq.push_back(32'h4);
      issue(1'b0, 4, 14'h0007, 14'h0008);
      wait_done("se_done");
      err_en = 1'b0;
      wq.delete();
      chk("se_err", {30'b0, done_err}, 32'd1);
      chk("se_nxfer", mon_n, 32'd4);
      chk("se_ntx", mon_tx, 32'd2);
      chk("se_done_next", done_cyc, last_xfer_cyc + 1);
      step(3);
      chk("se_err_held", {30'b0, err}, 32'd1);

      // Watchdog: PREADY stuck low on the CONFIG access
      clear_mon();
      stuck = 1'b1;
      issue(1'b0, 1, 14'h0009, 14'h000A);
      wait_done("wd_done");
      stuck = 1'b0;
      chk("wd_err", {30'b0, done_err}, 32'd2);
      chk("wd_acc_cycles", acc8, 32'd16);
      chk("wd_psel_at_done", {31'b0, psel_at_done}, 32'd0);
      chk("wd_nxfer", mon_n, 32'd0);
      chk("wd_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);

      // cmd_len = 0: only CONFIG and TIMEOUT
      clear_mon();
      issue(1'b0, 0, 14'h000B, 14'h000C);
      chk("len0_err_cleared", {30'b0, err}, 32'd0);
      wait_done("len0_done");
      chk("len0_nxfer", mon_n, 32'd2);
      chk("len0_a1", mon_addr[1], 32'd12);
      chk("len0_err", {30'b0, done_err}, 32'd0);

      // Reset asserted in the middle of W_A
      clear_mon();
      wait_addr = 32'd0; wait_n = 100;
      wq.push_back(32'hCAFE_0001); wq.push_back(32'hCAFE_0002);
      issue(1'b0, 2, 14'h000D, 14'h000E);
      begin
         int n = 0;
         while (!(PSEL && PENABLE && PADDR == 32'd0) && n < 100) begin step(1); n++; end
         chk("rst_reached_w_a", {31'b0, (PSEL && PENABLE && PADDR == 32'd0)}, 32'd1);
      end
      step(2);
      saved_done = done_cnt;
      #3 PRESETn = 1'b0;
      #1;
      chk("mid_rst_psel", {31'b0, PSEL}, 32'd0);
      chk("mid_rst_penable", {31'b0, PENABLE}, 32'd0);
      chk("mid_rst_pwdata", PWDATA, 32'd0);
      chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      wq.delete();
      wait_addr = 32'hFFFF_FFFF;
      step(2);
      PRESETn = 1'b1;
      step(4);
      chk("mid_rst_no_done", done_cnt, saved_done);
      chk("mid_rst_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
      chk("mid_rst_psel_after", {31'b0, PSEL}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
